// File: rtl/act_unit_scheduler.sv
// act_unit_scheduler
//   Owns the shared piecewise-linear activation unit. Streams LUT coefficient
//   words into a selected function slot, and time-multiplexes the unit across
//   the N_LANES values of a lane batch, collecting one result per lane.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   cfg_valid/ready/mask/data coefficient stream (mask sampled on first word)
//   cfg_done                  one-cycle pulse after the last word is written
//   in_valid/ready/data       lane batch in (lane i = in_data[i*DATA_W +: DATA_W])
//   in_mask, in_bypass        function slot / pass-through for the batch
//   out_valid/ready/data      activated batch out, same lane packing
//   act_write_*               LUT write port of the activation unit
//   act_x/mask/bypass         operand side of the activation unit
//   act_fx                    registered result from the activation unit
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for a config word (priority) or a lane batch
// LOAD     | writing coefficient words at addr 1..2^LUT_DEPTH-1
// ISSUE    | presenting lane[lane] for ACT_HOLD cycles, capturing act_fx
// OUTPUT   | result batch held on out_data until out_ready

module act_unit_scheduler #(
    parameter int N_LANES   = 4,
    parameter int DATA_W    = 16,
    parameter int LUT_DEPTH = 4,
    parameter int LUT_SIZE  = 32,
    parameter int MASK_SIZE = 2,
    parameter int ACT_HOLD  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [MASK_SIZE-1:0]        cfg_mask,
    input  logic [LUT_SIZE-1:0]         cfg_data,
    output logic                        cfg_done,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_LANES*DATA_W-1:0]   in_data,
    input  logic [MASK_SIZE-1:0]        in_mask,
    input  logic                        in_bypass,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N_LANES*DATA_W-1:0]   out_data,
    output logic                        act_write_enable,
    output logic [LUT_DEPTH-1:0]        act_write_addr,
    output logic [LUT_SIZE-1:0]         act_write_data,
    output logic [DATA_W-1:0]           act_x,
    output logic [MASK_SIZE-1:0]        act_mask,
    output logic                        act_bypass,
    input  logic [DATA_W-1:0]           act_fx
);

    localparam int LANE_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int HOLD_W = (ACT_HOLD > 1) ? $clog2(ACT_HOLD) : 1;
    localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(N_LANES - 1);
    localparam logic [HOLD_W-1:0]    LAST_HOLD = HOLD_W'(ACT_HOLD - 1);
    localparam logic [LUT_DEPTH-1:0] LAST_ADDR = {LUT_DEPTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_OUTPUT
    } state_t;

    state_t                      state_q, state_d;
    logic [LUT_DEPTH-1:0]        addr_q, addr_d;
    logic [MASK_SIZE-1:0]        cfg_mask_q, cfg_mask_d;
    logic                        cfg_done_q, cfg_done_d;
    logic [LANE_W-1:0]           lane_q, lane_d;
    logic [HOLD_W-1:0]           hold_q, hold_d;
    logic [N_LANES*DATA_W-1:0]   x_q, x_d;
    logic [MASK_SIZE-1:0]        bmask_q, bmask_d;
    logic                        bypass_q, bypass_d;
    logic [N_LANES*DATA_W-1:0]   result_q, result_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cfg_mask_q <= '0;
            cfg_done_q <= 1'b0;
            lane_q     <= '0;
            hold_q     <= '0;
            x_q        <= '0;
            bmask_q    <= '0;
            bypass_q   <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cfg_mask_q <= cfg_mask_d;
            cfg_done_q <= cfg_done_d;
            lane_q     <= lane_d;
            hold_q     <= hold_d;
            x_q        <= x_d;
            bmask_q    <= bmask_d;
            bypass_q   <= bypass_d;
            result_q   <= result_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cfg_mask_d = cfg_mask_q;
        cfg_done_d = 1'b0;
        lane_d     = lane_q;
        hold_d     = hold_q;
        x_d        = x_q;
        bmask_d    = bmask_q;
        bypass_d   = bypass_q;
        result_d   = result_q;

        cfg_ready        = 1'b0;
        in_ready         = 1'b0;
        out_valid        = 1'b0;
        act_write_enable = 1'b0;
        act_write_addr   = '0;
        act_write_data   = '0;
        act_x            = '0;
        act_mask         = '0;
        act_bypass       = 1'b0;

        // Handshake outputs are combinational from state; hold them low
        // while reset is asserted so the unit sees nothing during reset.
        if (!rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    cfg_ready = 1'b1;
                    in_ready  = !cfg_valid;
                    if (cfg_valid) begin
                        // First word goes straight to entry 0 in the accept cycle.
                        act_write_enable = 1'b1;
                        act_write_addr   = '0;
                        act_write_data   = cfg_data;
                        act_mask         = cfg_mask;
                        cfg_mask_d       = cfg_mask;
                        if (LUT_DEPTH == 0) begin
                            cfg_done_d = 1'b1;
                        end else begin
                            addr_d  = LUT_DEPTH'(1);
                            state_d = ST_LOAD;
                        end
                    end else if (in_valid) begin
                        x_d      = in_data;
                        bmask_d  = in_mask;
                        bypass_d = in_bypass;
                        lane_d   = '0;
                        hold_d   = '0;
                        state_d  = ST_ISSUE;
                    end
                end

                ST_LOAD: begin
                    cfg_ready        = 1'b1;
                    act_mask         = cfg_mask_q;
                    act_write_addr   = addr_q;
                    act_write_enable = cfg_valid;
                    if (cfg_valid) begin
                        act_write_data = cfg_data;
                        addr_d         = addr_q + 1'b1;
                        if (addr_q == LAST_ADDR) begin
                            addr_d     = '0;
                            cfg_done_d = 1'b1;
                            state_d    = ST_IDLE;
                        end
                    end
                end

                ST_ISSUE: begin
                    act_x      = x_q[lane_q*DATA_W +: DATA_W];
                    act_mask   = bmask_q;
                    act_bypass = bypass_q;
                    // LUT read inside the unit is registered, so act_fx is
                    // only valid on the last hold cycle of each operand.
                    if (hold_q == LAST_HOLD) begin
                        result_d[lane_q*DATA_W +: DATA_W] = act_fx;
                        hold_d = '0;
                        if (lane_q == LAST_LANE) begin
                            lane_d  = '0;
                            state_d = ST_OUTPUT;
                        end else begin
                            lane_d = lane_q + 1'b1;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end

                ST_OUTPUT: begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign cfg_done = cfg_done_q;
    assign out_data = result_q;

endmodule

// File: doc/act_unit_scheduler.md
Name: act_unit_scheduler

Overview:
- Sequencer that owns the shared activation-function unit (piecewise-linear LUT interpolator) and time-multiplexes it across N_LANES neuron accumulator outputs.
- Also owns LUT programming: streams coefficient words into the unit's table for a selected function slot (mask).
- Sits between the neuron-lane array and the layer output buffer; it is the only master of the activation unit's write and read inputs.

Parameters:
- N_LANES, 4, number of lane values per evaluation batch.
- DATA_W, 16, fixed-point width of x and fx (Q_INT+Q_FRAC).
- LUT_DEPTH, 4, LUT address bits per function slot; one slot holds 2^LUT_DEPTH entries.
- LUT_SIZE, 32, width of one LUT entry ({a_coef, b_coef}).
- MASK_SIZE, 2, function-slot select width.
- ACT_HOLD, 2, cycles each operand is held on act_x; act_fx is sampled on the last cycle. Must be ≥ 2 because the LUT read is registered.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- cfg_valid  in  1  coefficient word valid.
- cfg_ready  out  1  coefficient word accepted when cfg_valid && cfg_ready.
- cfg_mask  in  MASK_SIZE  target slot; sampled with the first word of a load.
- cfg_data  in  LUT_SIZE  coefficient word.
- cfg_done  out  1  one-cycle pulse after the last word of a load is written.
- in_valid  in  1  lane batch valid.
- in_ready  out  1  batch accepted when in_valid && in_ready.
- in_data  in  N_LANES*DATA_W  lane values; lane i is bits [i*DATA_W +: DATA_W].
- in_mask  in  MASK_SIZE  function slot for this batch.
- in_bypass  in  1  pass x through unchanged.
- out_valid  out  1  result batch valid.
- out_ready  in  1  result batch consumed when out_valid && out_ready.
- out_data  out  N_LANES*DATA_W  activated lane values, same lane packing as in_data.
- act_write_enable  out  1  to activation unit.
- act_write_addr  out  LUT_DEPTH  to activation unit.
- act_write_data  out  LUT_SIZE  to activation unit.
- act_x  out  DATA_W  operand to activation unit.
- act_mask  out  MASK_SIZE  to activation unit.
- act_bypass  out  1  to activation unit.
- act_fx  in  DATA_W  result from activation unit.

Behaviour:
- States: IDLE, LOAD, ISSUE, OUTPUT.
- Reset: state IDLE. All outputs 0: cfg_ready, cfg_done, in_ready, out_valid, out_data, act_write_enable, act_write_addr, act_write_data, act_x, act_mask, act_bypass. All counters 0.

IDLE:
- cfg_ready = 1.
- in_ready = !cfg_valid. Configuration has priority when cfg_valid and in_valid are high in the same cycle.
- Accepted cfg word: latch cfg_mask. In the same cycle drive act_write_enable=1, act_write_addr=0, act_write_data=cfg_data, act_mask=cfg_mask. Go to LOAD with addr=1.
- Accepted batch: register in_data, in_mask and in_bypass. Go to ISSUE with lane=0, hold=0.

LOAD:
- cfg_ready = 1; in_ready = 0.
- Each accepted word is written combinationally the same cycle at act_write_addr=addr, then addr increments.
- act_write_enable = cfg_valid, so no write occurs during gaps in cfg_valid.
- cfg_mask is ignored after the first word; the latched mask drives act_mask.
- Accepting the word at addr = 2^LUT_DEPTH-1 pulses cfg_done the next cycle and returns to IDLE.
- A single-word load (LUT_DEPTH=0) completes directly from IDLE.

ISSUE:
- in_ready = 0, cfg_ready = 0, act_write_enable = 0.
- act_x = registered lane[lane]; act_mask and act_bypass take the registered values.
- hold counts 0..ACT_HOLD-1. On hold = ACT_HOLD-1, capture act_fx into result slot [lane], then lane++ and hold=0.
- After capturing lane N_LANES-1, go to OUTPUT.
- Latency from batch accept to out_valid: N_LANES*ACT_HOLD+1 cycles (9 with defaults).

OUTPUT:
- out_valid = 1 and out_data stable until out_ready. Then out_valid drops the next cycle and the state returns to IDLE.
- No new batch or configuration is accepted while out_valid is high. Back-to-back batches are therefore separated by at least one IDLE cycle.

Boundary conditions:
- act_write_enable is never high outside LOAD or the IDLE→LOAD accept cycle.
- Reset mid-LOAD: the table keeps the entries already written, no cfg_done pulse occurs, and the next load restarts at addr 0.
- Reset mid-ISSUE or mid-OUTPUT: the batch is discarded and out_valid is 0.
- Overflow of act_fx is not detected here; it is passed through unmodified.

Test Plan:
1. Load slot 2 with words 0x1000_0000+k for k=0..15, cfg_valid continuous → act_write_addr steps 0..15 with act_mask=2; act_write_enable high for 16 cycles; exactly one cfg_done pulse, on the cycle after the 16th word.
2. Same load with cfg_valid low on every third cycle → no writes during gaps, 16 writes total, addresses contiguous, cfg_done once.
3. After loading a=1.0, b=0.5 in all entries of slot 1, batch {1.0, -2.0, 0.0, 3.25}, mask 1, bypass 0 → out_data {1.5, -1.5, 0.5, 3.75}; out_valid rises 9 cycles after accept.
4. Batch with in_bypass=1 → out_data equals in_data bit-exactly.
5. cfg_valid and in_valid asserted together in IDLE → config is accepted and in_ready stays 0 until cfg_done; the batch is then accepted in the first following IDLE cycle.
6. out_ready held low for 20 cycles → out_valid and out_data stable throughout, no new accepts. Then rst pulsed during ISSUE of the next batch → out_valid 0 and state IDLE (in_ready=1) immediately after rst deasserts.
